// File: rtl/sysid_check_master.sv
// Avalon-MM read master: fetches the sysid ID and build-timestamp words and flags mismatches.
// Optional per-read timeout is built only when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_check_master #(
  parameter int unsigned       ADDR_W             = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR          = '0,
  parameter logic [31:0]       EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0]       EXPECTED_TIMESTAMP = 32'd1457992953,
  parameter bit                AUTO_START         = 1'b1,
  parameter int unsigned       TIMEOUT_CYCLES     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam logic [ADDR_W-1:0] ADDR_ID = BASE_ADDR;
  localparam logic [ADDR_W-1:0] ADDR_TS = BASE_ADDR + ADDR_W'(4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t state, next_state;
  logic   auto_pending;
  logic   in_phase;
  logic   id_hit;
  logic   ts_hit;
  logic   expire;
  logic   abort;
  logic   start_check;

  // Data is only accepted in the matching wait state; anything else is stale.
  assign id_hit      = (state == WAIT_ID) && avm_readdatavalid;
  assign ts_hit      = (state == WAIT_TS) && avm_readdatavalid;
  assign in_phase    = (state == REQ_ID) || (state == WAIT_ID) ||
                       (state == REQ_TS) || (state == WAIT_TS);
  assign abort       = in_phase && expire && !id_hit && !ts_hit;
  assign start_check = (state == IDLE) && (next_state == REQ_ID);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start || auto_pending) next_state = REQ_ID;
      REQ_ID:  if (abort) next_state = FINISH;
               else if (!avm_waitrequest) next_state = WAIT_ID;
      WAIT_ID: if (id_hit) next_state = REQ_TS;
               else if (abort) next_state = FINISH;
      REQ_TS:  if (abort) next_state = FINISH;
               else if (!avm_waitrequest) next_state = WAIT_TS;
      WAIT_TS: if (ts_hit || abort) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One-shot launch request armed by reset, consumed on the first cycle after release.
  always_ff @(posedge clock) begin
    if (reset) auto_pending <= AUTO_START;
    else       auto_pending <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      avm_read    <= (next_state == REQ_ID) || (next_state == REQ_TS);
      avm_address <= (next_state == REQ_TS) ? ADDR_TS : ADDR_ID;
      busy        <= (next_state != IDLE);
      done        <= (next_state == FINISH);
      if (start_check) begin
        id_ok <= 1'b0;
        ts_ok <= 1'b0;
      end
      if (id_hit) begin
        id_value <= avm_readdata;
        id_ok    <= (avm_readdata == EXPECTED_ID);
      end
      if (ts_hit) begin
        ts_value <= avm_readdata;
        ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
      // An aborted phase and every phase after it report not-ok.
      if (abort) begin
        ts_ok <= 1'b0;
        if ((state == REQ_ID) || (state == WAIT_ID)) id_ok <= 1'b0;
      end
    end
  end

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt;
  logic        timeout_r;

  // Counts every cycle of the current read, request and wait together.
  always_ff @(posedge clock) begin
    if (reset)
      tmo_cnt <= '0;
    else if (((next_state == REQ_ID) && (state != REQ_ID)) ||
             ((next_state == REQ_TS) && (state != REQ_TS)))
      tmo_cnt <= '0;
    else if (in_phase)
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign expire = (tmo_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge clock) begin
    if (reset)            timeout_r <= 1'b0;
    else if (start_check) timeout_r <= 1'b0;
    else if (abort)       timeout_r <= 1'b1;
  end

  assign timeout = timeout_r;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: a behavioural Avalon slave with programmable stall/latency
// plus an arithmetic model of check latency and result flags.
`timescale 1ns/1ps
module tb_sysid_check_master;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1457992953;
  localparam int          TMO    = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest = 1'b1;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;
  logic              busy, done, id_ok, ts_ok, timeout;
  logic [31:0]       id_value, ts_value;

  int n_chk  = 0;
  int n_fail = 0;

  // Slave configuration and bookkeeping
  int          wait_n = 0;
  int          lat_n = 1;
  int          stall = 0;
  int          lat_left = 0;
  bit          outstanding = 1'b0;
  bit          mute = 1'b0;
  bit          allow_overlap = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] rd_addr = '0;
  logic [31:0] id_word = '0;
  logic [31:0] ts_word = '0;
  int          stall_viol = 0;
  int          proto_viol = 0;
  logic [31:0] addr_q[$];

  sysid_check_master #(
    .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE),
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .AUTO_START(1'b1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  // Slave drives on the falling edge so the DUT samples settled values.
  always @(negedge clock) begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom();
    if (stalled && (!avm_read || avm_address != st_addr)) stall_viol++;
    stalled = 1'b0;
    if (outstanding) begin
      lat_left--;
      if (lat_left <= 0) begin
        outstanding = 1'b0;
        if (!mute) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = (rd_addr == BASE) ? id_word : ts_word;
        end
      end
    end
    avm_waitrequest = 1'b1;
    if (avm_read && outstanding) begin
      if (!allow_overlap) proto_viol++;
      stalled = 1'b1;
      st_addr = avm_address;
    end else if (avm_read) begin
      if (stall < wait_n) begin
        stall++;
        stalled = 1'b1;
        st_addr = avm_address;
      end else begin
        avm_waitrequest = 1'b0;
        stall       = 0;
        outstanding = 1'b1;
        lat_left    = lat_n;
        rd_addr     = avm_address;
        addr_q.push_back(avm_address);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Runs one check. Caller is at a falling edge; cycle 0 is the current cycle.
  task automatic run_check(input logic [31:0] iw, input logic [31:0] tw,
                           input int w, input int l, input bit use_start,
                           input int busy_start_k, input string tag);
    int   k;
    bit   seen;
    logic [31:0] a0, a1;
    id_word = iw;
    ts_word = tw;
    wait_n  = w;
    lat_n   = l;
    addr_q.delete();
    if (use_start) start = 1'b1;
    seen = 1'b0;
    k    = 1;
    while (k <= 200 && !seen) begin
      @(negedge clock);
      start = (k == busy_start_k) ? 1'b1 : 1'b0;
      if (k == 1) begin
        chk({tag, "_busy_k1"}, 64'(busy), 64'(1));
        chk({tag, "_entry_clear"}, 64'({id_ok, ts_ok, timeout}), 64'(0));
      end
      if (done) seen = 1'b1;
      else      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(k), 64'(2 * (1 + w + l) + 1));
    chk({tag, "_id_value"}, 64'(id_value), 64'(iw));
    chk({tag, "_ts_value"}, 64'(ts_value), 64'(tw));
    chk({tag, "_id_ok"}, 64'(id_ok), 64'(iw == EXP_ID));
    chk({tag, "_ts_ok"}, 64'(ts_ok), 64'(tw == EXP_TS));
    chk({tag, "_timeout"}, 64'(timeout), 64'(0));
    chk({tag, "_nreads"}, 64'(addr_q.size()), 64'(2));
    a0 = (addr_q.size() > 0) ? addr_q[0] : 32'hxxxx_xxxx;
    a1 = (addr_q.size() > 1) ? addr_q[1] : 32'hxxxx_xxxx;
    chk({tag, "_addr0"}, 64'(a0), 64'(BASE));
    chk({tag, "_addr1"}, 64'(a1), 64'(BASE + 32'd4));
    @(negedge clock);
    chk({tag, "_done_1cyc"}, 64'({done, busy, avm_read}), 64'(0));
    chk({tag, "_stall_stable"}, 64'(stall_viol), 64'(0));
    chk({tag, "_one_outstanding"}, 64'(proto_viol), 64'(0));
  endtask

  initial begin
    logic [31:0] iw, tw;
    bit          found;
    int          k;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ctrl", 64'({avm_read, busy, done, id_ok, ts_ok, timeout}), 64'(0));
    chk("rst_values", 64'({id_value, ts_value}), 64'(0));
    chk("rst_addr", 64'(avm_address), 64'(BASE));

    // Auto-start after reset release, zero-wait slave
    reset = 1'b0;
    run_check(EXP_ID, EXP_TS, 0, 1, 1'b0, 0, "auto");

    // Stalled slave: 3 waitrequest cycles, data two cycles after acceptance
    run_check(EXP_ID, EXP_TS, 3, 2, 1'b1, 0, "stall");

    // Wrong timestamp
    run_check(EXP_ID, 32'h1234_5678, 0, 1, 1'b1, 0, "bad_ts");

    // Start while busy is ignored; a later start clears old flags on entry
    run_check(EXP_ID, EXP_TS, 1, 1, 1'b1, 2, "busy_start");
    repeat (3) @(negedge clock);
    chk("no_relaunch", 64'({busy, avm_read}), 64'(0));
    run_check(32'h0000_0001, EXP_TS, 0, 1, 1'b1, 0, "restart");

    // Randomised checks
    for (int i = 0; i < 6; i++) begin
      iw = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      tw = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      run_check(iw, tw, $urandom_range(0, 3), $urandom_range(1, 3), 1'b1, 0, "rand");
    end

    // Reset during WAIT_TS, stale data delivered afterwards
    id_word = 32'hA5A5_0001;
    ts_word = 32'h0BAD_F00D;
    wait_n  = 0;
    lat_n   = 6;
    addr_q.delete();
    start = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("mid_wait_ts", 64'({busy, avm_read}), 64'(2'b10));
    chk("mid_id_value", 64'(id_value), 64'(32'hA5A5_0001));
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_ctrl", 64'({avm_read, busy, done, id_ok, ts_ok, timeout}), 64'(0));
    chk("midrst_values", 64'({id_value, ts_value}), 64'(0));
    chk("midrst_addr", 64'(avm_address), 64'(BASE));
    allow_overlap = 1'b1;
    lat_n = 1;
    reset = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 20 && !found; j++) begin
      @(posedge clock);
      if (avm_readdatavalid) found = 1'b1;
    end
    chk("stale_delivered", 64'(found), 64'(1));
    @(negedge clock);
    chk("stale_ignored", 64'({id_value, ts_value}), 64'(0));
    chk("stale_flags", 64'({id_ok, ts_ok}), 64'(0));
    chk("auto_restart_busy", 64'(busy), 64'(1));
    found = 1'b0;
    for (int j = 0; j < 60 && !found; j++) begin
      @(negedge clock);
      if (done) found = 1'b1;
    end
    chk("restart_done", 64'(found), 64'(1));
    chk("restart_id", 64'(id_value), 64'(32'hA5A5_0001));
    chk("restart_ts", 64'(ts_value), 64'(32'h0BAD_F00D));
    chk("restart_flags", 64'({id_ok, ts_ok}), 64'({1'b0, 1'b0}));
    @(negedge clock);
    allow_overlap = 1'b0;

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Slave never returns data: ID read expires after TMO wait cycles
    mute  = 1'b1;
    lat_n = 1;
    start = 1'b1;
    found = 1'b0;
    k     = 1;
    while (k <= 60 && !found) begin
      @(negedge clock);
      start = 1'b0;
      if (done) found = 1'b1;
      else      k++;
    end
    chk("tmo_latency", 64'(k), 64'(2 + TMO));
    chk("tmo_flag", 64'(timeout), 64'(1));
    chk("tmo_ok_flags", 64'({id_ok, ts_ok}), 64'(0));
    chk("tmo_read_low", 64'(avm_read), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
